// File: rtl/axi_nm_arbiter.sv
// AXI4 N-master to 1-slave arbiter with independent round-robin write/read paths.
// Master index is prepended to the slave-side ID so responses route back by ID.
//
// Ports (m_* buses are NM lanes, lane i at [i*W +: W]):
//   clk_i, rst_i                  clock, synchronous active-high reset
//   m_aw*/m_w*/m_b*               per-master write address, data, response
//   m_ar*/m_r*                    per-master read address, data
//   s_aw*/s_w*/s_b*               slave write channels (id width SIW)
//   s_ar*/s_r*                    slave read channels (id width SIW)
module axi_nm_arbiter #(
  parameter int NM = 4,
  parameter int ID_BITS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_BITS = 8,
  localparam int MIW = $clog2(NM),
  localparam int SIW = ID_BITS + MIW,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NM*ID_BITS-1:0]    m_awid,
  input  logic [NM*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NM*LEN_BITS-1:0]   m_awlen,
  input  logic [NM*3-1:0]          m_awsize,
  input  logic [NM*2-1:0]          m_awburst,
  input  logic [NM-1:0]            m_awvalid,
  output logic [NM-1:0]            m_awready,
  input  logic [NM*DATA_WIDTH-1:0] m_wdata,
  input  logic [NM*SW-1:0]         m_wstrb,
  input  logic [NM-1:0]            m_wlast,
  input  logic [NM-1:0]            m_wvalid,
  output logic [NM-1:0]            m_wready,
  output logic [NM*ID_BITS-1:0]    m_bid,
  output logic [NM*3-1:0]          m_bresp,
  output logic [NM-1:0]            m_bvalid,
  input  logic [NM-1:0]            m_bready,
  input  logic [NM*ID_BITS-1:0]    m_arid,
  input  logic [NM*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NM*LEN_BITS-1:0]   m_arlen,
  input  logic [NM*3-1:0]          m_arsize,
  input  logic [NM*2-1:0]          m_arburst,
  input  logic [NM-1:0]            m_arvalid,
  output logic [NM-1:0]            m_arready,
  output logic [NM*ID_BITS-1:0]    m_rid,
  output logic [NM*DATA_WIDTH-1:0] m_rdata,
  output logic [NM*3-1:0]          m_rresp,
  output logic [NM-1:0]            m_rlast,
  output logic [NM-1:0]            m_rvalid,
  input  logic [NM-1:0]            m_rready,
  output logic [SIW-1:0]           s_awid,
  output logic [ADDR_WIDTH-1:0]    s_awaddr,
  output logic [LEN_BITS-1:0]      s_awlen,
  output logic [2:0]               s_awsize,
  output logic [1:0]               s_awburst,
  output logic                     s_awvalid,
  input  logic                     s_awready,
  output logic [DATA_WIDTH-1:0]    s_wdata,
  output logic [SW-1:0]            s_wstrb,
  output logic                     s_wlast,
  output logic                     s_wvalid,
  input  logic                     s_wready,
  input  logic [SIW-1:0]           s_bid,
  input  logic [2:0]               s_bresp,
  input  logic                     s_bvalid,
  output logic                     s_bready,
  output logic [SIW-1:0]           s_arid,
  output logic [ADDR_WIDTH-1:0]    s_araddr,
  output logic [LEN_BITS-1:0]      s_arlen,
  output logic [2:0]               s_arsize,
  output logic [1:0]               s_arburst,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  input  logic [SIW-1:0]           s_rid,
  input  logic [DATA_WIDTH-1:0]    s_rdata,
  input  logic [2:0]               s_rresp,
  input  logic                     s_rlast,
  input  logic                     s_rvalid,
  output logic                     s_rready
);

  typedef enum logic [1:0] {
    W_IDLE, W_ADDR, W_DATA, W_RESP
  } w_st_t;

  typedef enum logic [1:0] {
    R_IDLE, R_ADDR, R_DATA
  } r_st_t;

  // First requester at or after ptr, wrapping modulo NM.
  function automatic logic [MIW-1:0] rr_pick(
    input logic [NM-1:0]  req,
    input logic [MIW-1:0] ptr
  );
    logic [MIW-1:0] p;
    logic           hit;
    int             idx;
    p = '0;
    hit = 1'b0;
    for (int k = 0; k < NM; k++) begin
      idx = (int'(ptr) + k) % NM;
      if (!hit && req[idx]) begin
        p = MIW'(idx);
        hit = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic logic [MIW-1:0] rr_next(
    input logic [MIW-1:0] g
  );
    return (int'(g) == NM - 1) ? '0 : g + MIW'(1);
  endfunction

  w_st_t               w_st, w_nx;
  logic [MIW-1:0]      w_gnt, w_ptr, b_sel;
  logic [LEN_BITS-1:0] w_len, w_cnt;
  logic                aw_hs, w_hs, w_end, b_hs, b_hit;

  r_st_t               r_st, r_nx;
  logic [MIW-1:0]      r_gnt, r_ptr, r_sel;
  logic                ar_hs, r_end, r_hit;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  // Burst ends on wlast, or on the beat that fills awlen+1.
  assign w_end = w_hs && (s_wlast || w_cnt == w_len);
  assign b_hs  = s_bvalid && s_bready;
  assign b_sel = s_bid[SIW-1:ID_BITS];
  // Grant is always < NM, so a match also rules out bad indices.
  assign b_hit = b_sel == w_gnt;

  assign ar_hs = s_arvalid && s_arready;
  assign r_end = s_rvalid && s_rready && s_rlast;
  assign r_sel = s_rid[SIW-1:ID_BITS];
  assign r_hit = r_sel == r_gnt;

  assign s_awid    = {w_gnt, m_awid[int'(w_gnt)*ID_BITS +: ID_BITS]};
  assign s_awaddr  = m_awaddr[int'(w_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_awlen   = m_awlen[int'(w_gnt)*LEN_BITS +: LEN_BITS];
  assign s_awsize  = m_awsize[int'(w_gnt)*3 +: 3];
  assign s_awburst = m_awburst[int'(w_gnt)*2 +: 2];
  assign s_wdata   = m_wdata[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign s_wstrb   = m_wstrb[int'(w_gnt)*SW +: SW];
  assign s_wlast   = m_wlast[w_gnt];
  assign m_bid     = {NM{s_bid[ID_BITS-1:0]}};
  assign m_bresp   = {NM{s_bresp}};

  assign s_arid    = {r_gnt, m_arid[int'(r_gnt)*ID_BITS +: ID_BITS]};
  assign s_araddr  = m_araddr[int'(r_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_arlen   = m_arlen[int'(r_gnt)*LEN_BITS +: LEN_BITS];
  assign s_arsize  = m_arsize[int'(r_gnt)*3 +: 3];
  assign s_arburst = m_arburst[int'(r_gnt)*2 +: 2];
  assign m_rid     = {NM{s_rid[ID_BITS-1:0]}};
  assign m_rdata   = {NM{s_rdata}};
  assign m_rresp   = {NM{s_rresp}};
  assign m_rlast   = {NM{s_rlast}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_st  <= W_IDLE;
      w_gnt <= '0;
      w_ptr <= '0;
      w_len <= '0;
      w_cnt <= '0;
    end else begin
      w_st <= w_nx;
      if (w_st == W_IDLE && |m_awvalid) begin
        w_gnt <= rr_pick(m_awvalid, w_ptr);
        w_ptr <= rr_next(rr_pick(m_awvalid, w_ptr));
      end
      if (w_st == W_ADDR && aw_hs) begin
        w_len <= s_awlen;
        w_cnt <= '0;
      end
      if (w_st == W_DATA && w_hs)
        w_cnt <= w_cnt + LEN_BITS'(1);
    end
  end

  always_comb begin
    w_nx = w_st;
    unique case (w_st)
      W_IDLE: if (|m_awvalid) w_nx = W_ADDR;
      W_ADDR: if (aw_hs) w_nx = W_DATA;
      W_DATA: if (w_end) w_nx = W_RESP;
      W_RESP: if (b_hs) w_nx = W_IDLE;
      default: w_nx = W_IDLE;
    endcase
  end

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    unique case (w_st)
      W_ADDR: begin
        s_awvalid        = m_awvalid[w_gnt];
        m_awready[w_gnt] = s_awready;
      end
      W_DATA: begin
        s_wvalid        = m_wvalid[w_gnt];
        m_wready[w_gnt] = s_wready;
      end
      W_RESP: begin
        if (b_hit) begin
          m_bvalid[b_sel] = s_bvalid;
          s_bready        = m_bready[b_sel];
        end else begin
          s_bready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_st  <= R_IDLE;
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      r_st <= r_nx;
      if (r_st == R_IDLE && |m_arvalid) begin
        r_gnt <= rr_pick(m_arvalid, r_ptr);
        r_ptr <= rr_next(rr_pick(m_arvalid, r_ptr));
      end
    end
  end

  always_comb begin
    r_nx = r_st;
    unique case (r_st)
      R_IDLE: if (|m_arvalid) r_nx = R_ADDR;
      R_ADDR: if (ar_hs) r_nx = R_DATA;
      R_DATA: if (r_end) r_nx = R_IDLE;
      default: r_nx = R_IDLE;
    endcase
  end

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    unique case (r_st)
      R_ADDR: begin
        s_arvalid        = m_arvalid[r_gnt];
        m_arready[r_gnt] = s_arready;
      end
      R_DATA: begin
        if (r_hit) begin
          m_rvalid[r_sel] = s_rvalid;
          s_rready        = m_rready[r_sel];
        end else begin
          s_rready = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_nm_arbiter.sv
// Directed bench for axi_nm_arbiter, NM=4.
// Drives master lanes and a scripted slave; checks with immediate assertions.
module tb_axi_nm_arbiter;

  logic         clk;
  logic         rst_i;
  logic [15:0]  m_awid;
  logic [127:0] m_awaddr;
  logic [31:0]  m_awlen;
  logic [11:0]  m_awsize;
  logic [7:0]   m_awburst;
  logic [3:0]   m_awvalid, m_awready;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic [3:0]   m_wlast, m_wvalid, m_wready;
  logic [15:0]  m_bid;
  logic [11:0]  m_bresp;
  logic [3:0]   m_bvalid, m_bready;
  logic [15:0]  m_arid;
  logic [127:0] m_araddr;
  logic [31:0]  m_arlen;
  logic [11:0]  m_arsize;
  logic [7:0]   m_arburst;
  logic [3:0]   m_arvalid, m_arready;
  logic [15:0]  m_rid;
  logic [127:0] m_rdata;
  logic [11:0]  m_rresp;
  logic [3:0]   m_rlast, m_rvalid, m_rready;
  logic [5:0]   s_awid;
  logic [31:0]  s_awaddr;
  logic [7:0]   s_awlen;
  logic [2:0]   s_awsize;
  logic [1:0]   s_awburst;
  logic         s_awvalid, s_awready;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wlast, s_wvalid, s_wready;
  logic [5:0]   s_bid;
  logic [2:0]   s_bresp;
  logic         s_bvalid, s_bready;
  logic [5:0]   s_arid;
  logic [31:0]  s_araddr;
  logic [7:0]   s_arlen;
  logic [2:0]   s_arsize;
  logic [1:0]   s_arburst;
  logic         s_arvalid, s_arready;
  logic [5:0]   s_rid;
  logic [31:0]  s_rdata;
  logic [2:0]   s_rresp;
  logic         s_rlast, s_rvalid, s_rready;

  int n_cmp = 0;
  int n_bad = 0;

  axi_nm_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] outs();
    return {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
            m_awready, m_wready, m_bvalid, m_arready, m_rvalid};
  endfunction

  function automatic logic [31:0] ad(input int m);
    return 32'h4000_0000 | 32'(m << 12);
  endfunction

  function automatic logic [31:0] wd(input int m, input int b);
    return 32'hD000_0000 | 32'(m << 8) | 32'(b);
  endfunction

  function automatic logic [31:0] rd(input int b);
    return 32'hBEEF_0000 | 32'(b);
  endfunction

  task automatic req_aw(input int m, input logic [3:0] id,
                        input logic [7:0] len);
    m_awid[m*4 +: 4] = id;
    m_awaddr[m*32 +: 32] = ad(m);
    m_awlen[m*8 +: 8] = len;
    m_awsize[m*3 +: 3] = 3'd2;
    m_awburst[m*2 +: 2] = 2'd1;
    m_wstrb[m*4 +: 4] = 4'hF;
    m_awvalid[m] = 1'b1;
  endtask

  task automatic req_ar(input int m, input logic [3:0] id,
                        input logic [7:0] len);
    m_arid[m*4 +: 4] = id;
    m_araddr[m*32 +: 32] = ad(m) | 32'h800;
    m_arlen[m*8 +: 8] = len;
    m_arsize[m*3 +: 3] = 3'd2;
    m_arburst[m*2 +: 2] = 2'd1;
    m_arvalid[m] = 1'b1;
  endtask

  task automatic slave_write(input int m, input logic [5:0] sid,
                             input int beats, input int stall_at,
                             input logic [5:0] bid);
    int k;
    k = 0;
    while (!s_awvalid && k < 8) begin
      @(posedge clk); #2;
      k++;
    end
    chk("aw_valid", 64'(s_awvalid), 64'(1));
    chk("aw_id", 64'(s_awid), 64'(sid));
    chk("aw_addr", 64'(s_awaddr), 64'(ad(m)));
    chk("aw_ctl", 64'({s_awlen, s_awsize, s_awburst}),
        64'({8'(beats - 1), 3'd2, 2'd1}));
    s_awready = 1'b1;
    #1;
    chk("aw_ready", 64'(m_awready), 64'(1) << m);
    @(posedge clk); #1;
    m_awvalid[m] = 1'b0;
    s_awready = 1'b0;
    m_wvalid[m] = 1'b1;
    s_wready = 1'b1;
    for (int b = 0; b < beats; b++) begin
      m_wdata[m*32 +: 32] = wd(m, b);
      m_wlast[m] = (b == beats - 1);
      if (b == stall_at) begin
        s_wready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk("w_stall_rdy", 64'(m_wready), 64'(0));
          chk("w_stall_dat", 64'(s_wdata), 64'(wd(m, b)));
          @(posedge clk); #1;
        end
        s_wready = 1'b1;
      end
      #1;
      chk("w_valid", 64'(s_wvalid), 64'(1));
      chk("w_data", 64'({s_wdata, s_wstrb, s_wlast}),
          64'({wd(m, b), 4'hF, 1'(b == beats - 1)}));
      chk("w_ready", 64'(m_wready), 64'(1) << m);
      @(posedge clk); #1;
    end
    m_wvalid[m] = 1'b0;
    m_wlast[m] = 1'b0;
    s_wready = 1'b0;
    s_bvalid = 1'b1;
    s_bid = bid;
    s_bresp = 3'b010;
    m_bready = '0;
    if (bid == sid) begin
      #1;
      chk("b_valid", 64'(m_bvalid), 64'(1) << m);
      chk("b_hold", 64'(s_bready), 64'(0));
      chk("b_payload", 64'({m_bid[m*4 +: 4], m_bresp[m*3 +: 3]}),
          64'({sid[3:0], 3'b010}));
      m_bready[m] = 1'b1;
      #1;
      chk("b_ready", 64'(s_bready), 64'(1));
    end else begin
      m_bready = '1;
      #1;
      chk("b_drain_valid", 64'(m_bvalid), 64'(0));
      chk("b_drain_ready", 64'(s_bready), 64'(1));
    end
    @(posedge clk); #1;
    s_bvalid = 1'b0;
    m_bready = '0;
    #1;
    chk("w_idle", 64'(s_bready), 64'(0));
  endtask

  task automatic slave_read(input int m, input logic [5:0] sid,
                            input int beats);
    int k;
    k = 0;
    while (!s_arvalid && k < 8) begin
      @(posedge clk); #2;
      k++;
    end
    chk("ar_valid", 64'(s_arvalid), 64'(1));
    chk("ar_id", 64'(s_arid), 64'(sid));
    chk("ar_ctl", 64'({s_araddr, s_arlen, s_arsize, s_arburst}),
        64'({ad(m) | 32'h800, 8'(beats - 1), 3'd2, 2'd1}));
    s_arready = 1'b1;
    #1;
    chk("ar_ready", 64'(m_arready), 64'(1) << m);
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0;
    s_arready = 1'b0;
    for (int b = 0; b < beats; b++) begin
      s_rvalid = 1'b1;
      s_rid = sid;
      s_rdata = rd(b);
      s_rresp = 3'b001;
      s_rlast = (b == beats - 1);
      m_rready[m] = 1'b1;
      #1;
      chk("r_valid", 64'(m_rvalid), 64'(1) << m);
      chk("r_payload", 64'({m_rid[m*4 +: 4], m_rdata[m*32 +: 32],
          m_rresp[m*3 +: 3], m_rlast[m]}),
          64'({sid[3:0], rd(b), 3'b001, 1'(b == beats - 1)}));
      chk("r_ready", 64'(s_rready), 64'(1));
      @(posedge clk); #1;
    end
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    m_rready = '0;
    #1;
    chk("r_idle", 64'(s_rready), 64'(0));
  endtask

  initial begin
    int k;
    rst_i = 1'b1;
    {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid} = '0;
    {m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready} = '0;
    {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid} = '0;
    m_rready = '0;
    {s_awready, s_wready, s_bid, s_bresp, s_bvalid} = '0;
    {s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'(outs()), 64'(0));
    rst_i = 1'b0;

    req_aw(1, 4'hA, 8'd0);
    req_aw(3, 4'h5, 8'd0);
    slave_write(1, {2'd1, 4'hA}, 1, -1, {2'd1, 4'hA});
    slave_write(3, {2'd3, 4'h5}, 1, -1, {2'd3, 4'h5});

    for (int m = 0; m < 4; m++) req_aw(m, 4'(m + 8), 8'd0);
    for (int i = 0; i < 40; i++) begin
      slave_write(i % 4, {2'(i % 4), 4'((i % 4) + 8)}, 1, -1,
                  {2'(i % 4), 4'((i % 4) + 8)});
      req_aw(i % 4, 4'((i % 4) + 8), 8'd0);
    end
    m_awvalid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    k = 0;
    while ((s_awvalid || s_bready || s_wvalid) && k < 8) begin
      s_awready = 1'b1;
      s_wready = 1'b1;
      s_bvalid = 1'b1;
      s_bid = s_awid;
      @(posedge clk); #1;
      k++;
    end
    {s_awready, s_wready, s_bvalid} = '0;
    @(posedge clk); #1;
    chk("stream_drain", 64'(outs()), 64'(0));

    req_aw(2, 4'hC, 8'd3);
    req_ar(0, 4'h6, 8'd7);
    fork
      slave_write(2, {2'd2, 4'hC}, 4, 2, {2'd2, 4'hC});
      slave_read(0, {2'd0, 4'h6}, 8);
    join

    req_aw(1, 4'h2, 8'd0);
    slave_write(1, {2'd1, 4'h2}, 1, -1, {2'd3, 4'h2});
    req_aw(1, 4'h9, 8'd1);
    slave_write(1, {2'd1, 4'h9}, 2, -1, {2'd1, 4'h9});

    req_aw(1, 4'h7, 8'd3);
    k = 0;
    while (!s_awvalid && k < 8) begin
      @(posedge clk); #2;
      k++;
    end
    chk("rst_aw_id", 64'(s_awid), 64'({2'd1, 4'h7}));
    s_awready = 1'b1;
    @(posedge clk); #1;
    m_awvalid[1] = 1'b0;
    s_awready = 1'b0;
    m_wvalid[1] = 1'b1;
    s_wready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      m_wdata[32 +: 32] = wd(1, b);
      @(posedge clk); #1;
    end
    m_wdata[32 +: 32] = wd(1, 2);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outs", 64'(outs()), 64'(0));
    rst_i = 1'b0;
    m_wvalid = '0;
    s_wready = 1'b0;
    req_aw(0, 4'h3, 8'd0);
    req_aw(2, 4'h4, 8'd0);
    slave_write(0, {2'd0, 4'h3}, 1, -1, {2'd0, 4'h3});
    slave_write(2, {2'd2, 4'h4}, 1, -1, {2'd2, 4'h4});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
